// File: rtl/gmii_rx_frame_check.sv
// GMII receive front end: strips preamble/SFD, forwards frame bytes, checks FCS/length/rx_er
// and issues one good/bad verdict per frame. Define RX_FCS_STRIP_EN to withhold the 4 FCS bytes.
module gmii_rx_frame_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int MAX_PRE = 15
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic        rx_good,
  output logic        rx_bad,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_TRUNC = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_DROP  = 3'd5;

  localparam logic [7:0]  MAX_PRE_C   = 8'(MAX_PRE);
  localparam logic [10:0] MIN_LEN_C   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_C   = 11'(MAX_LEN);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // input capture stage
  logic [7:0]  rxd_q;
  logic        dv_q, er_q;

  logic [2:0]  state_q, state_d;
  logic [7:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic        err_q, err_d;
  logic        sent_q, sent_d;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        good_q, good_d;
  logic        bad_q, bad_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;

`ifdef RX_FCS_STRIP_EN
  logic [3:0][7:0] dly_q, dly_d;
  logic [2:0]      fill_q, fill_d;
`endif

  logic frame_bad;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign frame_bad = (crc_q != CRC_RESIDUE) || (len_q < MIN_LEN_C) || err_q;

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    len_d     = len_q;
    crc_d     = crc_q;
    err_d     = err_q;
    sent_d    = sent_q;
    data_d    = 8'h00;
    valid_d   = 1'b0;
    good_d    = 1'b0;
    bad_d     = 1'b0;
`ifdef RX_FCS_STRIP_EN
    dly_d     = dly_q;
    fill_d    = fill_q;
`endif

    case (state_q)
      ST_IDLE, ST_CHECK: begin
        // CHECK doubles as IDLE so a frame after a 1-cycle gap keeps its first preamble byte
        if (state_q == ST_CHECK && !sent_q) begin
          bad_d  = frame_bad;
          good_d = !frame_bad;
        end
        sent_d  = 1'b0;
        state_d = ST_IDLE;
        if (dv_q) begin
          if (rxd_q == 8'h55) begin
            state_d   = ST_PRE;
            pre_cnt_d = 8'd1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PRE: begin
        if (!dv_q) begin
          state_d = ST_DROP;
        end else if (rxd_q == 8'hD5) begin
          state_d = ST_DATA;
          len_d   = 11'd0;
          crc_d   = 32'hFFFFFFFF;
          err_d   = 1'b0;
          sent_d  = 1'b0;
`ifdef RX_FCS_STRIP_EN
          fill_d  = 3'd0;
`endif
        end else if (rxd_q == 8'h55) begin
          if (pre_cnt_q >= MAX_PRE_C) begin
            state_d = ST_DROP;
          end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (!dv_q) begin
          state_d = ST_CHECK;
        end else if (len_q == MAX_LEN_C) begin
          // a byte beyond MAX_LEN: stop forwarding, verdict comes from TRUNC
          state_d = ST_TRUNC;
        end else begin
          crc_d = crc_step(crc_q, rxd_q);
          len_d = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
          if (er_q) begin
            err_d = 1'b1;
          end
`ifdef RX_FCS_STRIP_EN
          dly_d = {rxd_q, dly_q[3:1]};
          if (fill_q == 3'd4) begin
            data_d  = dly_q[0];
            valid_d = 1'b1;
          end else begin
            fill_d = fill_q + 3'd1;
          end
`else
          data_d  = rxd_q;
          valid_d = 1'b1;
`endif
        end
      end

      ST_TRUNC: begin
        // first TRUNC cycle is one cycle after the last forwarded byte, same as CHECK
        if (!sent_q) begin
          bad_d  = 1'b1;
          sent_d = 1'b1;
        end
        if (!dv_q) begin
          state_d = ST_CHECK;
        end
      end

      ST_DROP: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    good_cnt_d = (good_d && good_cnt_q != 16'hFFFF) ? good_cnt_q + 16'd1 : good_cnt_q;
    bad_cnt_d  = (bad_d && bad_cnt_q != 16'hFFFF) ? bad_cnt_q + 16'd1 : bad_cnt_q;
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      rxd_q      <= 8'h00;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      state_q    <= ST_IDLE;
      pre_cnt_q  <= 8'd0;
      len_q      <= 11'd0;
      crc_q      <= 32'hFFFFFFFF;
      err_q      <= 1'b0;
      sent_q     <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      good_cnt_q <= 16'd0;
      bad_cnt_q  <= 16'd0;
`ifdef RX_FCS_STRIP_EN
      dly_q      <= '0;
      fill_q     <= 3'd0;
`endif
    end else begin
      rxd_q      <= gmii_rxd;
      dv_q       <= gmii_rx_dv;
      er_q       <= gmii_rx_er;
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      err_q      <= err_d;
      sent_q     <= sent_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
`ifdef RX_FCS_STRIP_EN
      dly_q      <= dly_d;
      fill_q     <= fill_d;
`endif
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_good       = good_q;
  assign rx_bad        = bad_q;
  assign good_cnt      = good_cnt_q;
  assign bad_cnt       = bad_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame_check.sv
// Directed bench for gmii_rx_frame_check; follows RX_FCS_STRIP_EN when defined.
module tb_gmii_rx_frame_check;

`ifdef RX_FCS_STRIP_EN
  localparam int STRIP = 4;
`else
  localparam int STRIP = 0;
`endif
  localparam int MAXL = 1518;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_good;
  logic        rx_bad;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_rx_frame_check dut (
    .rx_clk       (rx_clk),
    .rx_rst       (rx_rst),
    .gmii_rxd     (gmii_rxd),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rx_er   (gmii_rx_er),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_good      (rx_good),
    .rx_bad       (rx_bad),
    .good_cnt     (good_cnt),
    .bad_cnt      (bad_cnt)
  );

  always #4 rx_clk = ~rx_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];
  int good_seen = 0;
  int bad_seen = 0;
  int timing_err = 0;
  logic v1 = 1'b0;
  logic v2 = 1'b0;
  int g0, b0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // one clock: drive inputs, then sample outputs 1 ns after the edge
  task automatic step(input logic [7:0] d, input logic dv, input logic er);
    gmii_rxd   = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    @(posedge rx_clk);
    #1;
    if (rx_data_valid) out_q.push_back(rx_data);
    if (rx_good || rx_bad) begin
      if (rx_data_valid || v1 || !v2 || (rx_good && rx_bad)) timing_err++;
    end
    if (rx_good) good_seen++;
    if (rx_bad) bad_seen++;
    v2 = v1;
    v1 = rx_data_valid;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
  endtask

  // bit-serial reflected CRC-32 over tx_q, FCS appended LSB byte first
  task automatic append_fcs();
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    foreach (tx_q[k]) begin
      b = tx_q[k];
      for (int i = 0; i < 8; i++) begin
        if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
        else             c = c >> 1;
      end
    end
    fcs = ~c;
    tx_q.push_back(fcs[7:0]);
    tx_q.push_back(fcs[15:8]);
    tx_q.push_back(fcs[23:16]);
    tx_q.push_back(fcs[31:24]);
  endtask

  task automatic build_frame(input int n, input int mult);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'(i * mult));
    append_fcs();
  endtask

  task automatic send_frame(input int er_idx, input int gap);
    for (int i = 0; i < 7; i++) step(8'h55, 1'b1, 1'b0);
    step(8'hD5, 1'b1, 1'b0);
    foreach (tx_q[i]) step(tx_q[i], 1'b1, (i == er_idx));
    idle(gap);
  endtask

  task automatic add_expect();
    int n;
    n = (tx_q.size() > MAXL) ? MAXL : tx_q.size();
    n = n - STRIP;
    for (int i = 0; i < n; i++) exp_q.push_back(tx_q[i]);
  endtask

  task automatic check_out(input string tag);
    int mism;
    int n;
    mism = 0;
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    check({tag, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) mism++;
    check({tag, "_bytes"}, mism, 0);
    $display("frame %s: %0d bytes out, good_cnt=%0d bad_cnt=%0d", tag, out_q.size(), good_cnt, bad_cnt);
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rx_rst     = 1'b1;
    gmii_rxd   = 8'h00;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    check("rst_valid", rx_data_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_good", rx_good, 0);
    check("rst_bad", rx_bad, 0);
    check("rst_good_cnt", good_cnt, 0);
    check("rst_bad_cnt", bad_cnt, 0);
    rx_rst = 1'b0;
    idle(3);

    // 1: good 64-byte frame
    g0 = good_seen; b0 = bad_seen;
    build_frame(60, 1);
    send_frame(-1, 12);
    add_expect();
    check_out("t1");
    check("t1_good", good_seen - g0, 1);
    check("t1_bad", bad_seen - b0, 0);
    check("t1_good_cnt", good_cnt, 1);

    // 2: byte 10 corrupted, FCS left as for the original
    g0 = good_seen; b0 = bad_seen;
    build_frame(60, 1);
    tx_q[10] = tx_q[10] ^ 8'hFF;
    send_frame(-1, 12);
    add_expect();
    check_out("t2");
    check("t2_good", good_seen - g0, 0);
    check("t2_bad", bad_seen - b0, 1);
    check("t2_bad_cnt", bad_cnt, 1);

    // 3a: 40-byte runt with valid FCS
    g0 = good_seen; b0 = bad_seen;
    build_frame(36, 1);
    send_frame(-1, 12);
    add_expect();
    check_out("t3_runt");
    check("t3_runt_bad", bad_seen - b0, 1);
    check("t3_runt_good", good_seen - g0, 0);

    // 3b: 2000-byte frame, truncated at MAX_LEN
    g0 = good_seen; b0 = bad_seen;
    build_frame(1996, 1);
    send_frame(-1, 12);
    add_expect();
    check_out("t3_long");
    check("t3_long_bad", bad_seen - b0, 1);
    check("t3_long_good", good_seen - g0, 0);
    check("t3_bad_cnt", bad_cnt, 3);

    // 4: rx_er on byte 30, then a good frame after a 1-cycle gap
    g0 = good_seen; b0 = bad_seen;
    build_frame(60, 1);
    send_frame(30, 1);
    add_expect();
    build_frame(60, 3);
    send_frame(-1, 12);
    add_expect();
    check_out("t4");
    check("t4_bad", bad_seen - b0, 1);
    check("t4_good", good_seen - g0, 1);
    check("t4_good_cnt", good_cnt, 2);
    check("t4_bad_cnt", bad_cnt, 4);

    // 5: bad preamble byte with dv held, then an over-long preamble without SFD
    g0 = good_seen; b0 = bad_seen;
    for (int i = 0; i < 3; i++) step(8'h55, 1'b1, 1'b0);
    step(8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 96; i++) step(8'(i + 7), 1'b1, 1'b0);
    idle(2);
    for (int i = 0; i < 20; i++) step(8'h55, 1'b1, 1'b0);
    idle(12);
    check("t5_len", out_q.size(), 0);
    check("t5_verdicts", (good_seen - g0) + (bad_seen - b0), 0);
    check("t5_good_cnt", good_cnt, 2);
    check("t5_bad_cnt", bad_cnt, 4);
    $display("frame t5: %0d bytes out, good_cnt=%0d bad_cnt=%0d", out_q.size(), good_cnt, bad_cnt);
    out_q.delete();

    // 6: reset at data byte 20, then a good frame
    build_frame(60, 1);
    for (int i = 0; i < 7; i++) step(8'h55, 1'b1, 1'b0);
    step(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i <= 20; i++) step(tx_q[i], 1'b1, 1'b0);
    check("t6_pre_valid", rx_data_valid, 1);
    rx_rst = 1'b1;
    #1;
    check("t6_rst_valid", rx_data_valid, 0);
    check("t6_rst_data", rx_data, 0);
    check("t6_rst_good_cnt", good_cnt, 0);
    check("t6_rst_bad_cnt", bad_cnt, 0);
    g0 = good_seen; b0 = bad_seen;
    out_q.delete();
    idle(3);
    rx_rst = 1'b0;
    idle(12);
    check("t6_no_verdict", (good_seen - g0) + (bad_seen - b0), 0);
    check("t6_no_data", out_q.size(), 0);
    build_frame(60, 5);
    send_frame(-1, 12);
    add_expect();
    check_out("t6");
    check("t6_good", good_seen - g0, 1);
    check("t6_good_cnt", good_cnt, 1);
    check("t6_bad_cnt", bad_cnt, 0);

    check("verdict_timing", timing_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
